// File: rtl/core_pkg.sv
// Shared definitions for the attention-core sequencer: inst bit map, state set
// and the per-state instruction builder.
package core_pkg;

  localparam int unsigned INST_W        = 17;
  localparam int unsigned INST_OFIFO_RD = 16;
  localparam int unsigned QKADD_MSB     = 15;
  localparam int unsigned QKADD_LSB     = 12;
  localparam int unsigned PADD_MSB      = 11;
  localparam int unsigned PADD_LSB      = 8;
  localparam int unsigned INST_EXECUTE  = 7;
  localparam int unsigned INST_LOAD     = 6;
  localparam int unsigned INST_QMEM_RD  = 5;
  localparam int unsigned INST_QMEM_WR  = 4;
  localparam int unsigned INST_KMEM_RD  = 3;
  localparam int unsigned INST_KMEM_WR  = 2;
  localparam int unsigned INST_PMEM_RD  = 1;
  localparam int unsigned INST_PMEM_WR  = 0;

  typedef enum logic [2:0] {
    IDLE,
    WR_Q,
    WR_K,
    LOAD,
    EXEC,
    DRAIN,
    RDOUT,
    DONE
  } seq_state_e;

  // Instruction issued by an active cycle of the given phase; silent phases give 0.
  function automatic logic [INST_W-1:0] build_inst(input seq_state_e st,
                                                   input logic [3:0] addr);
    logic [INST_W-1:0] w_word;
    w_word = '0;
    case (st)
      WR_Q: begin
        w_word[INST_QMEM_WR]           = 1'b1;
        w_word[QKADD_MSB:QKADD_LSB]    = addr;
      end
      WR_K: begin
        w_word[INST_KMEM_WR]           = 1'b1;
        w_word[QKADD_MSB:QKADD_LSB]    = addr;
      end
      LOAD: begin
        w_word[INST_KMEM_RD]           = 1'b1;
        w_word[INST_LOAD]              = 1'b1;
        w_word[QKADD_MSB:QKADD_LSB]    = addr;
      end
      EXEC: begin
        w_word[INST_QMEM_RD]           = 1'b1;
        w_word[INST_EXECUTE]           = 1'b1;
        w_word[QKADD_MSB:QKADD_LSB]    = addr;
      end
      RDOUT: begin
        w_word[INST_OFIFO_RD]          = 1'b1;
        w_word[INST_PMEM_WR]           = 1'b1;
        w_word[PADD_MSB:PADD_LSB]      = addr;
      end
      default: w_word[INST_PMEM_RD]    = 1'b0;
    endcase
    return w_word;
  endfunction

endpackage

// File: rtl/core_seq_ctrl.sv
// Tile sequencer: streams Q/K into memory, loads K, executes, drains the array
// and pops the OFIFO into pmem, driving a registered 17-bit inst word.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int total_cycle  = 8,
  parameter int col          = 8,
  parameter int drain_cycles = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] inst,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] LAST_TC  = 8'(total_cycle - 1);
  localparam logic [7:0] LAST_COL = 8'(col - 1);
  localparam logic [7:0] LAST_DRN = 8'(drain_cycles - 1);

  seq_state_e  r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [16:0] r_inst, w_inst_nxt;
  logic        r_busy, r_done;
  logic        w_wr_phase, w_hs;

  assign w_wr_phase = (r_state == WR_Q) || (r_state == WR_K);
  assign w_hs       = in_valid & w_wr_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)                     w_state_nxt = WR_Q;
      WR_Q:    if (w_hs && r_cnt == LAST_TC)  w_state_nxt = WR_K;
      WR_K:    if (w_hs && r_cnt == LAST_TC)  w_state_nxt = LOAD;
      LOAD:    if (r_cnt == LAST_COL)         w_state_nxt = EXEC;
      EXEC:    if (r_cnt == LAST_TC)          w_state_nxt = DRAIN;
      DRAIN:   if (r_cnt == LAST_DRN)         w_state_nxt = RDOUT;
      RDOUT:   if (r_cnt == LAST_TC)          w_state_nxt = DONE;
      DONE:                                   w_state_nxt = IDLE;
      default:                                w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // The inst for the current cycle's cnt is registered, so the core sees it one edge later.
  always_comb begin
    w_inst_nxt = '0;
    w_cnt_nxt  = r_cnt;
    case (r_state)
      WR_Q, WR_K: begin
        if (w_hs) begin
          w_inst_nxt = build_inst(r_state, r_cnt[3:0]);
          w_cnt_nxt  = r_cnt + 8'd1;
        end
      end
      LOAD, EXEC, RDOUT: begin
        w_inst_nxt = build_inst(r_state, r_cnt[3:0]);
        w_cnt_nxt  = r_cnt + 8'd1;
      end
      DRAIN:   w_cnt_nxt = r_cnt + 8'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
    if (abort || (w_state_nxt != r_state)) w_cnt_nxt  = '0;
    if (abort)                             w_inst_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_inst <= w_inst_nxt;
      r_busy <= (w_state_nxt != IDLE);
      r_done <= (w_state_nxt == DONE);
    end
  end

  assign in_ready = w_wr_phase;
  assign inst     = r_inst;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: a tile-timeline model (write handshakes, then a flat
// post-write cycle index) checked every cycle, plus hand-computed anchors.
module tb_core_seq_ctrl;

  localparam int unsigned TC     = 8;
  localparam int unsigned COL    = 8;
  localparam int unsigned DRN    = 10;
  localparam int unsigned P_LAST = COL + 2 * TC + DRN;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] inst;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [16:0] tr   [0:79];
  logic        b_tr [0:79];
  int          bcnt;
  int          dcnt;

  core_seq_ctrl #(
    .total_cycle (TC),
    .col         (COL),
    .drain_cycles(DRN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .inst    (inst),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] f_wr(input int unsigned a, input logic is_k);
    logic [16:0] v;
    v = is_k ? 17'h00004 : 17'h00010;
    return v | (17'(a) << 12);
  endfunction

  // Post-write timeline: load, execute, drain gap, readout, then the done cycle.
  function automatic logic [16:0] f_post(input int unsigned p);
    if (p < COL)                return 17'h00048 | (17'(p) << 12);
    if (p < COL + TC)           return 17'h000A0 | (17'(p - COL) << 12);
    if (p < COL + TC + DRN)     return 17'h00000;
    if (p < COL + 2 * TC + DRN) return 17'h10001 | (17'(p - COL - TC - DRN) << 8);
    return 17'h00000;
  endfunction

  logic        m_active = 1'b0;
  int unsigned m_wr     = 0;
  int unsigned m_p      = 0;
  logic [16:0] e_inst   = '0;
  logic        e_busy   = 1'b0;
  logic        e_done   = 1'b0;
  logic        e_ready;

  assign e_ready = m_active && (m_wr < 2 * TC);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_wr     <= 0;
      m_p      <= 0;
      e_inst   <= '0;
      e_busy   <= 1'b0;
      e_done   <= 1'b0;
    end else if (!m_active) begin
      e_inst <= '0;
      e_done <= 1'b0;
      if (start && !abort) begin
        m_active <= 1'b1;
        m_wr     <= 0;
        m_p      <= 0;
        e_busy   <= 1'b1;
      end else begin
        e_busy <= 1'b0;
      end
    end else if (abort) begin
      m_active <= 1'b0;
      e_inst   <= '0;
      e_busy   <= 1'b0;
      e_done   <= 1'b0;
    end else if (m_wr < 2 * TC) begin
      e_busy <= 1'b1;
      e_done <= 1'b0;
      if (in_valid) begin
        e_inst <= (m_wr < TC) ? f_wr(m_wr, 1'b0) : f_wr(m_wr - TC, 1'b1);
        m_wr   <= m_wr + 1;
      end else begin
        e_inst <= '0;
      end
    end else begin
      e_inst <= f_post(m_p);
      m_p    <= m_p + 1;
      if (m_p == P_LAST) begin
        m_active <= 1'b0;
        e_busy   <= 1'b0;
        e_done   <= 1'b0;
      end else begin
        e_busy <= 1'b1;
        e_done <= (m_p == P_LAST - 1);
      end
    end
  end

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("model_inst", inst, e_inst);
    chk("model_busy", 17'(busy), 17'(e_busy));
    chk("model_done", 17'(done), 17'(e_done));
    chk("model_in_ready", 17'(in_ready), 17'(e_ready));
  endtask

  task automatic rec(input int k);
    tr[k]   = inst;
    b_tr[k] = busy;
    if (busy) bcnt++;
    if (done) dcnt++;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_inst", inst, 17'h00000);
    chk("rst_busy", 17'(busy), 17'h0);
    chk("rst_done", 17'(done), 17'h0);
    chk("rst_in_ready", 17'(in_ready), 17'h0);

    reset = 1'b1;
    start = 1'b0;
    repeat (5) cyc();
    chk("idle_hold_busy", 17'(busy), 17'h0);

    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    cyc();
    chk("abort_start_idle", 17'(busy), 17'h0);

    // full tile, in_valid always high
    in_valid = 1'b1;
    start    = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int k = 0; k < 70; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      rec(k);
    end
    chk("full_busy_cycles", 17'(bcnt), 17'd51);
    chk("full_done_pulses", 17'(dcnt), 17'd1);
    chk("full_first", tr[0], 17'h00000);
    chk("full_q0", tr[1], 17'h00010);
    chk("full_q7", tr[8], 17'h07010);
    chk("full_k0", tr[9], 17'h00004);
    chk("full_load3", tr[20], 17'h03048);
    chk("full_exec7", tr[32], 17'h070A0);
    chk("full_drain", tr[37], 17'h00000);
    chk("full_rd5", tr[48], 17'h10501);
    chk("full_rd7", tr[50], 17'h10701);

    // backpressure during WR_Q
    in_valid = 1'b0;
    start    = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int k = 0; k < 70; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      in_valid = (k < 16) ? ((k % 2) == 1) : 1'b1;
      rec(k);
    end
    chk("bp_q0", tr[2], 17'h00010);
    chk("bp_stall", tr[15], 17'h00000);
    chk("bp_q7", tr[16], 17'h07010);
    chk("bp_k0", tr[17], 17'h00004);
    chk("bp_busy_cycles", 17'(bcnt), 17'd59);
    chk("bp_done_pulses", 17'(dcnt), 17'd1);

    // abort in EXEC at cnt=3, then replay
    in_valid = 1'b1;
    start    = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (k == 0)  start = 1'b0;
      if (k == 27) abort = 1'b1;
      if (k == 28) abort = 1'b0;
      rec(k);
    end
    chk("abort_e2", tr[27], 17'h020A0);
    chk("abort_inst", tr[28], 17'h00000);
    chk("abort_busy", 17'(b_tr[28]), 17'h0);
    chk("abort_no_done", 17'(dcnt), 17'd0);

    start = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int k = 0; k < 70; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      rec(k);
    end
    chk("replay_q0", tr[1], 17'h00010);
    chk("replay_busy_cycles", 17'(bcnt), 17'd51);
    chk("replay_done_pulses", 17'(dcnt), 17'd1);

    // start pulses during LOAD and DONE are ignored
    start = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int k = 0; k < 70; k++) begin
      cyc();
      if (k == 0 || k == 20 || k == 51) start = 1'b0;
      if (k == 19 || k == 50) start = 1'b1;
      rec(k);
    end
    chk("spur_busy_cycles", 17'(bcnt), 17'd51);
    chk("spur_done_pulses", 17'(dcnt), 17'd1);
    chk("spur_idle_after", 17'(b_tr[55]), 17'h0);

    // async reset between edges during RDOUT at cnt=5
    start = 1'b1;
    for (int k = 0; k < 48; k++) begin
      cyc();
      if (k == 0) start = 1'b0;
      rec(k);
    end
    chk("rdout_rd4", tr[47], 17'h10401);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_inst", inst, 17'h00000);
    chk("async_rst_busy", 17'(busy), 17'h0);
    chk("async_rst_done", 17'(done), 17'h0);
    repeat (2) cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("post_rst_idle", 17'(busy), 17'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
